// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame scheduler: FSM state encoding,
// default frame geometry/pipeline latency and the delay-line tag layout.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } sched_state_t;

    // 128-point frame carried as 4 samples per beat
    localparam int DEF_FRAME_LEN = 32;
    // Beats take this many cycles to reach the final pipeline tap
    localparam int DEF_PIPE_LAT  = 40;

    // Bit positions of the {eof, sof, valid} tag carried through the delay line
    localparam int TAG_W     = 3;
    localparam int TAG_VALID = 0;
    localparam int TAG_SOF   = 1;
    localparam int TAG_EOF   = 2;

endpackage

// File: rtl/fft_valid_dly.sv
// Width x depth shift register with synchronous clear. Carries the per-beat
// control tags alongside the datapath so they emerge at the final tap in step
// with the data they describe.
module fft_valid_dly #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 40
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift one stage per cycle; clear wipes every in-flight tag at once
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/fft_frame_sched.sv
// FFT frame scheduler. Aligns to the source's start-of-frame marker, gates
// the first-stage enable, tracks the beat index within a frame, and delays
// valid/sof/eof tags to the final tap so downstream logic sees frame
// boundaries. Sample data never passes through this block.
module fft_frame_sched
    import fft_ctrl_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int PIPE_LAT  = DEF_PIPE_LAT,
    parameter int FCNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_valid,
    input  logic                         i_sof,
    output logic                         o_enable,
    output logic [$clog2(FRAME_LEN)-1:0] o_in_cnt,
    output logic                         o_out_valid,
    output logic                         o_out_sof,
    output logic                         o_out_eof,
    output logic [FCNT_W-1:0]            o_frame_cnt,
    output logic                         o_sof_err,
    output logic                         o_busy
);

    localparam int CNT_W   = $clog2(FRAME_LEN);
    localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

    localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(FRAME_LEN - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

    sched_state_t       state;
    logic [CNT_W-1:0]   in_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               stop_req;
    logic               sof_err;
    logic [FCNT_W-1:0]  frame_cnt;

    logic               accept;
    logic               mis_sof;
    logic               stop_pend;
    logic               tag_sof;
    logic               tag_eof;
    logic [TAG_W-1:0]   tag_in;
    logic [TAG_W-1:0]   tag_out;

    // Decide whether this cycle's beat enters the pipeline and how it is tagged
    always_comb begin
        accept    = 1'b0;
        mis_sof   = 1'b0;
        tag_sof   = 1'b0;
        tag_eof   = 1'b0;
        stop_pend = stop_req | i_stop;
        case (state)
            ST_SYNC:   accept = i_valid & i_sof & ~i_stop;
            ST_ACTIVE: accept = i_valid & ~(stop_pend & (in_cnt == '0));
            default:   accept = 1'b0;
        endcase
        mis_sof = accept & i_sof & (in_cnt != '0);
        tag_sof = accept & ((in_cnt == '0) | i_sof);
        tag_eof = accept & ~mis_sof & (in_cnt == LAST_CNT);
    end

    // Scheduler FSM with beat index, stop request, drain timer and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_cnt    <= '0;
            drain_cnt <= '0;
            stop_req  <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            sof_err <= mis_sof;
            if (accept) begin
                if (mis_sof) begin
                    in_cnt <= CNT_W'(1);
                end else if (in_cnt == LAST_CNT) begin
                    in_cnt <= '0;
                end else begin
                    in_cnt <= in_cnt + CNT_W'(1);
                end
            end
            case (state)
                ST_IDLE: begin
                    stop_req <= 1'b0;
                    if (i_start && !i_stop) begin
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (i_stop) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (stop_pend && ((in_cnt == '0) || tag_eof)) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                        stop_req  <= 1'b0;
                    end else begin
                        stop_req <= stop_pend;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign tag_in[TAG_VALID] = accept;
    assign tag_in[TAG_SOF]   = tag_sof;
    assign tag_in[TAG_EOF]   = tag_eof;

    fft_valid_dly #(
        .WIDTH (TAG_W),
        .DEPTH (PIPE_LAT)
    ) u_valid_dly (
        .clk  (clk),
        .clr  (rst),
        .din  (tag_in),
        .dout (tag_out)
    );

    // Count frames whose last beat has reached the final tap
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (tag_out[TAG_VALID] && tag_out[TAG_EOF]) begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
        end
    end

    assign o_enable    = accept & ~rst;
    assign o_in_cnt    = rst ? '0 : in_cnt;
    assign o_out_valid = tag_out[TAG_VALID] & ~rst;
    assign o_out_sof   = tag_out[TAG_SOF] & ~rst;
    assign o_out_eof   = tag_out[TAG_EOF] & ~rst;
    assign o_frame_cnt = rst ? '0 : frame_cnt;
    assign o_sof_err   = sof_err & ~rst;
    assign o_busy      = (state != ST_IDLE) & ~rst;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed self-checking bench for fft_frame_sched with default parameters
// (32 beats per frame, 40-cycle pipeline latency).
module tb_fft_frame_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic       i_stop;
    logic       i_valid;
    logic       i_sof;
    logic       o_enable;
    logic [4:0] o_in_cnt;
    logic       o_out_valid;
    logic       o_out_sof;
    logic       o_out_eof;
    logic [7:0] o_frame_cnt;
    logic       o_sof_err;
    logic       o_busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int  sof_q[$];
    int  eof_q[$];
    bit  vmap[int];

    int c0, s0, m0, g0, e1, s2, e2, r0;

    fft_frame_sched #(
        .FRAME_LEN (32),
        .PIPE_LAT  (40),
        .FCNT_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_valid     (i_valid),
        .i_sof       (i_sof),
        .o_enable    (o_enable),
        .o_in_cnt    (o_in_cnt),
        .o_out_valid (o_out_valid),
        .o_out_sof   (o_out_sof),
        .o_out_eof   (o_out_eof),
        .o_frame_cnt (o_frame_cnt),
        .o_sof_err   (o_sof_err),
        .o_busy      (o_busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle index used to timestamp stimulus and observed tap events
    always @(posedge clk) cyc <= cyc + 1;

    // Record the final-tap outputs mid-cycle, away from the active edge
    always @(negedge clk) begin
        vmap[cyc] = o_out_valid;
        if (o_out_sof) sof_q.push_back(cyc);
        if (o_out_eof) eof_q.push_back(cyc);
    end

    function automatic int count_valid(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) begin
            if (vmap.exists(i) && vmap[i]) n++;
        end
        return n;
    endfunction

    // Drive one cycle of inputs just after the rising edge, then let it settle
    task automatic apply_stimulus(input logic v, input logic s, input logic st,
                                  input logic sp, input logic r);
        @(posedge clk);
        #1;
        i_valid = v;
        i_sof   = s;
        i_start = st;
        i_stop  = sp;
        rst     = r;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_valid = 1'b0; i_sof = 1'b0;

        // Reset state
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_output("rst_busy",      32'(o_busy),      0);
        check_output("rst_in_cnt",    32'(o_in_cnt),    0);
        check_output("rst_enable",    32'(o_enable),    0);
        check_output("rst_out_valid", 32'(o_out_valid), 0);
        check_output("rst_frame_cnt", 32'(o_frame_cnt), 0);
        check_output("rst_sof_err",   32'(o_sof_err),   0);
        for (int k = 0; k < 2; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Two aligned frames back-to-back, stop requested mid second frame
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sof_q.delete(); eof_q.delete();
        for (int b = 0; b < 64; b++) begin
            apply_stimulus(1'b1, (b == 0 || b == 32), 1'b0, (b == 50), 1'b0);
            if (b == 0) begin
                c0 = cyc;
                check_output("a_first_enable", 32'(o_enable), 1);
            end
            if (b == 1)  check_output("a_cnt_after_sof", 32'(o_in_cnt), 1);
            if (b == 32) check_output("a_cnt_wrap",      32'(o_in_cnt), 0);
            if (b == 33) check_output("a_no_sof_err",    32'(o_sof_err), 0);
        end
        for (int k = 1; k <= 40; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("a_busy_drain_end", 32'(o_busy),      1);
        check_output("a_fcnt_drain_end", 32'(o_frame_cnt), 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("a_idle_after_drain", 32'(o_busy),      0);
        check_output("a_frame_cnt",        32'(o_frame_cnt), 2);
        check_output("a_sof_count",  32'(sof_q.size()), 2);
        check_output("a_sof0_cycle", 32'(sof_q[0] - c0), 40);
        check_output("a_sof1_cycle", 32'(sof_q[1] - c0), 72);
        check_output("a_eof_count",  32'(eof_q.size()), 2);
        check_output("a_eof0_cycle", 32'(eof_q[0] - c0), 71);
        check_output("a_eof1_cycle", 32'(eof_q[1] - c0), 103);
        check_output("a_valid_before", 32'(vmap[c0 + 39]), 0);
        check_output("a_valid_beats",  32'(count_valid(c0, c0 + 104)), 64);

        // Sync discard, misaligned sof, input gap, stop mid frame
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sof_q.delete(); eof_q.delete();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check_output("b_nosof_enable", 32'(o_enable), 0);
            if (i == 0) check_output("b_sync_busy", 32'(o_busy), 1);
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        s0 = cyc;
        check_output("b_sof_enable", 32'(o_enable), 1);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 0) check_output("b_cnt_after_sof", 32'(o_in_cnt), 1);
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        m0 = cyc;
        check_output("b_cnt_before_missof", 32'(o_in_cnt), 17);
        check_output("b_missof_enable",     32'(o_enable), 1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("b_sof_err_pulse", 32'(o_sof_err), 1);
        check_output("b_cnt_restart",   32'(o_in_cnt),  1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("b_sof_err_clear", 32'(o_sof_err), 0);
        check_output("b_cnt_two",       32'(o_in_cnt),  2);
        for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 0) g0 = cyc;
            check_output("b_gap_cnt_hold", 32'(o_in_cnt), 10);
            check_output("b_gap_enable",   32'(o_enable), 0);
        end
        for (int i = 0; i < 22; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 21) e1 = cyc;
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        s2 = cyc;
        check_output("b_cnt_new_frame", 32'(o_in_cnt), 0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("b_cnt_at_stop", 32'(o_in_cnt), 5);
        for (int i = 0; i < 26; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 25) e2 = cyc;
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("b_drain_no_accept", 32'(o_enable), 0);
        check_output("b_drain_busy",      32'(o_busy),   1);
        for (int k = 2; k <= 40; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("b_busy_drain_end", 32'(o_busy),      1);
        check_output("b_fcnt_drain_end", 32'(o_frame_cnt), 3);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("b_idle_after_drain", 32'(o_busy),      0);
        check_output("b_frame_cnt",        32'(o_frame_cnt), 4);
        check_output("b_eof_count",  32'(eof_q.size()), 2);
        check_output("b_eof0_cycle", 32'(eof_q[0] - e1), 40);
        check_output("b_eof1_cycle", 32'(eof_q[1] - e2), 40);
        check_output("b_sof_count",  32'(sof_q.size()), 3);
        check_output("b_sof0_cycle", 32'(sof_q[0] - s0), 40);
        check_output("b_sof1_cycle", 32'(sof_q[1] - m0), 40);
        check_output("b_sof2_cycle", 32'(sof_q[2] - s2), 40);
        check_output("b_hole_pre",   32'(vmap[g0 + 39]), 1);
        check_output("b_hole_first", 32'(vmap[g0 + 40]), 0);
        check_output("b_hole_last",  32'(vmap[g0 + 42]), 0);
        check_output("b_hole_post",  32'(vmap[g0 + 43]), 1);

        // Reset in the middle of a frame discards everything in flight
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("c_cnt_before_rst", 32'(o_in_cnt), 20);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        r0 = cyc;
        check_output("c_rst_enable", 32'(o_enable), 0);
        check_output("c_rst_busy",   32'(o_busy),   0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("c_post_busy",      32'(o_busy),      0);
        check_output("c_post_in_cnt",    32'(o_in_cnt),    0);
        check_output("c_post_frame_cnt", 32'(o_frame_cnt), 0);
        check_output("c_post_out_valid", 32'(o_out_valid), 0);
        check_output("c_post_sof_err",   32'(o_sof_err),   0);
        for (int k = 0; k < 50; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("c_no_valid_after_rst", 32'(count_valid(r0, cyc - 1)), 0);
        check_output("c_frame_cnt_final",    32'(o_frame_cnt), 0);

        // Start and stop together in IDLE, then stop while in SYNC
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("d_start_stop_idle", 32'(o_busy), 0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("d_sync_busy", 32'(o_busy), 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("d_sync_stop_idle", 32'(o_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_sched.md
FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

Interface
REQ-001 Parameter FRAME_LEN, default 32: input cycles per 128-point frame (4 samples per cycle).
REQ-002 Parameter PIPE_LAT, default 40: cycles from an accepted input beat to its result at the final pipeline tap.
REQ-003 Parameter FCNT_W, default 8: output frame-counter width.
REQ-004 clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_start  in  1  single-cycle pulse that arms the scheduler.
REQ-007 i_stop  in  1  single-cycle pulse that requests stop after the current frame.
REQ-008 i_valid  in  1  source presents a 4-sample input beat this cycle.
REQ-009 i_sof  in  1  beat is sample group 0 of a frame; qualified by i_valid.
REQ-010 o_enable  out  1  data-valid strobe to the first pipeline stage.
REQ-011 o_in_cnt  out  $clog2(FRAME_LEN)  index of the next beat within the frame.
REQ-012 o_out_valid  out  1  final-tap outputs hold a valid beat.
REQ-013 o_out_sof / o_out_eof  out  1 each  first / last beat of an output frame.
REQ-014 o_frame_cnt  out  FCNT_W  completed output frames, wrapping.
REQ-015 o_sof_err  out  1  one-cycle pulse on a misaligned i_sof.
REQ-016 o_busy  out  1  state is not IDLE.

Function
REQ-017 FSM states: IDLE, SYNC, ACTIVE, DRAIN.
REQ-018 IDLE -> SYNC on i_start; i_start is ignored in any other state.
REQ-019 SYNC -> ACTIVE on the cycle i_valid&i_sof is high; that beat is accepted (o_enable=1, o_in_cnt becomes 1).
REQ-020 In SYNC, beats without i_sof are discarded (o_enable=0).
REQ-021 In ACTIVE, o_enable = i_valid combinationally; a gap (i_valid=0) holds o_in_cnt.
REQ-022 o_in_cnt increments on each accepted beat and wraps from FRAME_LEN-1 to 0.
REQ-023 i_sof accepted while o_in_cnt != 0: pulse o_sof_err, accept the beat as a new frame start (o_in_cnt becomes 1), and mark the truncated frame's delayed eof absent.
REQ-024 i_stop in ACTIVE latches a stop request.
REQ-025 The stop request takes effect when the beat with o_in_cnt = FRAME_LEN-1 is accepted, or immediately if o_in_cnt = 0: enter DRAIN; no further beats are accepted.
REQ-026 i_stop in SYNC -> IDLE directly.
REQ-027 DRAIN counts PIPE_LAT cycles, then enters IDLE; o_out_* keep following the delay line meanwhile.
REQ-028 A delay line of PIPE_LAT cycles carries {enable, sof, eof}.
REQ-029 o_out_valid / o_out_sof / o_out_eof equal the delay-line tap.
REQ-030 sof is tagged on accepted beats at count 0; eof is tagged on accepted beats at count FRAME_LEN-1.
REQ-031 o_frame_cnt increments when o_out_valid&o_out_eof is high, wrapping at 2^FCNT_W.
REQ-032 i_start and i_stop in the same cycle: i_stop wins (IDLE stays IDLE; in ACTIVE, i_start is ignored).
REQ-033 Latency: o_out_valid rises exactly PIPE_LAT cycles after the corresponding o_enable.

Reset
REQ-034 On rst: state IDLE; all counters, the delay line and the stop request are cleared.
REQ-035 During rst, every output is 0.
REQ-036 rst mid-frame or in DRAIN discards all in-flight tags; no o_out_valid appears after reset until new beats are accepted.

Structure
REQ-037 Shared package fft_ctrl_pkg holds the FSM state enum and the default FRAME_LEN and PIPE_LAT constants.
REQ-038 One sub-module fft_valid_dly: a parameterised width x depth shift register with synchronous clear, used for REQ-028.
REQ-039 The scheduler does not touch sample data; it only gates the enables of the topfft stages.

Verification
REQ-040 Start; 2 back-to-back aligned frames (64 beats); then stop:
- o_out_sof at cycles 40 and 72 after the first o_enable;
- o_out_eof at cycles 71 and 103;
- o_frame_cnt = 2; IDLE 40 cycles after the last beat.
REQ-041 Start; 5 beats without i_sof, then an aligned frame -> first 5 beats have o_enable=0; o_in_cnt = 1 after the sof beat.
REQ-042 i_sof at o_in_cnt = 17 -> o_sof_err pulses once; o_in_cnt = 1; the truncated frame never produces o_out_eof; o_frame_cnt does not increment for it.
REQ-043 3-cycle i_valid gap at o_in_cnt = 10 -> o_in_cnt holds at 10; o_out_valid shows the same 3-cycle hole PIPE_LAT later.
REQ-044 i_stop at o_in_cnt = 5 -> the frame completes to count 31; DRAIN; o_busy low after 40 more cycles.
REQ-045 rst at o_in_cnt = 20 -> next cycle all outputs 0; no o_out_valid for 50 cycles with i_valid=0; o_frame_cnt = 0.
